// File: rtl/tap_counter.sv
// tap_counter
// ---------------------------------------------------------------------------
// Programmable index counter for symmetric tap or coefficient addressing.
// A start pulse samples the run configuration (limit, direction, wrap or
// one-shot). The count then walks 0..limit (up) or limit..0 (down) on each
// enabled cycle. It either wraps back to the start value, or stops in DONE
// once the terminal value has been consumed.
//
// Parameters
//   WIDTH        counter / limit width (1..32)
//   RESET_LIMIT  limit register value after reset (default all ones)
//
// Ports
//   clk       in   single clock, rising edge
//   rst       in   synchronous active-high reset
//   en        in   advance enable (effective only while running)
//   start     in   sample limit/dir/oneshot and begin a run (ignored in RUN)
//   clr       in   abort: count to start value, state to IDLE
//   load      in   overwrite count with min(load_val, limit register)
//   load_val  in   WIDTH  value for load
//   limit     in   WIDTH  terminal value, sampled on start
//   dir       in   0 = count up, 1 = count down, sampled on start
//   oneshot   in   0 = wrap at terminal, 1 = stop at terminal, sampled on start
//   count     out  WIDTH  current index (registered)
//   mirror    out  WIDTH  limit register minus count (partner index)
//   tc        out  count equals the terminal value of the current direction
//   wrap      out  advance from the terminal value happens this cycle
//   busy      out  state is RUN
//   done      out  state is DONE
// ---------------------------------------------------------------------------
module tap_counter #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_LIMIT = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic             dir,
    input  logic             oneshot,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] mirror,
    output logic             tc,
    output logic             wrap,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [WIDTH-1:0]  count_reg;
    logic [WIDTH-1:0]  count_next;
    logic [WIDTH-1:0]  limit_reg;
    logic [WIDTH-1:0]  limit_next;
    logic              dir_reg;
    logic              dir_next;
    logic              oneshot_reg;
    logic              oneshot_next;

    // Terminal and start values depend only on the sampled configuration.
    logic [WIDTH-1:0]  terminal_val;
    logic [WIDTH-1:0]  start_val;
    logic              at_terminal;
    logic              start_ok;
    logic              advance;

    assign terminal_val = dir_reg ? '0 : limit_reg;
    assign start_val    = dir_reg ? limit_reg : '0;
    assign at_terminal  = (count_reg == terminal_val);
    // A start during RUN is ignored; load and clr take precedence over it.
    assign start_ok     = start && !clr && !load && (state_reg != RUN);
    assign advance      = en && !clr && !load && (state_reg == RUN);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        if (clr) begin
            state_next = IDLE;
        end else if (load) begin
            state_next = state_reg;
        end else begin
            case (state_reg)
                IDLE:    if (start) state_next = RUN;
                RUN:     if (en && at_terminal && oneshot_reg) state_next = DONE;
                DONE:    if (start) state_next = RUN;
                default: state_next = IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        busy   = (state_reg == RUN);
        done   = (state_reg == DONE);
        tc     = at_terminal;
        // Counts are modulo 2**WIDTH; count never exceeds limit, so no borrow.
        mirror = limit_reg - count_reg;
        // rst also kills the pulse so an abandoned run never reports a wrap.
        wrap   = advance && at_terminal && !rst;
    end

    // -----------------------------------------------------------------------
    // Datapath next values, in priority order clr > load > start > advance
    // -----------------------------------------------------------------------
    always_comb begin
        count_next   = count_reg;
        limit_next   = limit_reg;
        dir_next     = dir_reg;
        oneshot_next = oneshot_reg;
        if (clr) begin
            count_next = start_val;
        end else if (load) begin
            // Clamp so the index can never leave the 0..limit window.
            count_next = (load_val > limit_reg) ? limit_reg : load_val;
        end else if (start_ok) begin
            limit_next   = limit;
            dir_next     = dir;
            oneshot_next = oneshot;
            count_next   = dir ? limit : '0;
        end else if (advance) begin
            if (at_terminal) begin
                // One-shot holds on the terminal value; wrap mode restarts.
                count_next = oneshot_reg ? count_reg : start_val;
            end else if (dir_reg) begin
                count_next = count_reg - WIDTH'(1);
            end else begin
                count_next = count_reg + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg   <= '0;
            limit_reg   <= RESET_LIMIT;
            dir_reg     <= 1'b0;
            oneshot_reg <= 1'b0;
        end else begin
            count_reg   <= count_next;
            limit_reg   <= limit_next;
            dir_reg     <= dir_next;
            oneshot_reg <= oneshot_next;
        end
    end

    assign count = count_reg;

endmodule

// File: tb/tb_tap_counter.sv
module tb_tap_counter;

    logic       clk = 1'b0;
    logic       rst, en, start, clr, load, dir, oneshot;
    logic [7:0] load_val, limit;
    logic [7:0] count, mirror;
    logic       tc, wrap, busy, done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tap_counter #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .clr(clr), .load(load),
        .load_val(load_val), .limit(limit), .dir(dir), .oneshot(oneshot),
        .count(count), .mirror(mirror), .tc(tc), .wrap(wrap), .busy(busy), .done(done)
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // well away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        rst = 0; en = 0; start = 0; clr = 0; load = 0;
        load_val = 0; limit = 0; dir = 0; oneshot = 0;
    endtask

    task automatic do_reset();
        quiet_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic do_start(input logic [7:0] lim, input logic d, input logic os);
        limit = lim; dir = d; oneshot = os; start = 1;
        tick();
        start = 0;
        limit = 8'hA5; dir = ~d; oneshot = ~os; // later changes must not matter
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        if (count !== 8'd0)    begin $display("FAIL reset_count actual=%0d required=0", count); failures++; end checks++;
        if (mirror !== 8'd255) begin $display("FAIL reset_mirror actual=%0d required=255", mirror); failures++; end checks++;
        if (tc !== 1'b0)       begin $display("FAIL reset_tc actual=%0b required=0", tc); failures++; end checks++;
        if (wrap !== 1'b0)     begin $display("FAIL reset_wrap actual=%0b required=0", wrap); failures++; end checks++;
        if (busy !== 1'b0)     begin $display("FAIL reset_busy actual=%0b required=0", busy); failures++; end checks++;
        if (done !== 1'b0)     begin $display("FAIL reset_done actual=%0b required=0", done); failures++; end checks++;
        $display("txn test_reset count=%0d mirror=%0d", count, mirror);
    endtask

    task automatic test_up_wrap();
        int exp;
        do_reset();
        do_start(8'd4, 1'b0, 1'b0);
        en = 1;
        for (int i = 0; i < 7; i++) begin
            #1;
            exp = i % 5;
            if (count !== 8'(exp))      begin $display("FAIL upwrap_count[%0d] actual=%0d required=%0d", i, count, exp); failures++; end checks++;
            if (mirror !== 8'(4 - exp)) begin $display("FAIL upwrap_mirror[%0d] actual=%0d required=%0d", i, mirror, 4 - exp); failures++; end checks++;
            if (wrap !== (exp == 4))    begin $display("FAIL upwrap_wrap[%0d] actual=%0b required=%0b", i, wrap, exp == 4); failures++; end checks++;
            tick();
        end
        en = 0;
        $display("txn test_up_wrap final_count=%0d", count);
    endtask

    task automatic test_down_oneshot();
        do_reset();
        do_start(8'd3, 1'b1, 1'b1);
        en = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (count !== 8'(3 - i))  begin $display("FAIL down_count[%0d] actual=%0d required=%0d", i, count, 3 - i); failures++; end checks++;
            if (wrap !== (i == 3))    begin $display("FAIL down_wrap[%0d] actual=%0b required=%0b", i, wrap, i == 3); failures++; end checks++;
            tick();
        end
        if (done !== 1'b1) begin $display("FAIL down_done actual=%0b required=1", done); failures++; end checks++;
        if (busy !== 1'b0) begin $display("FAIL down_busy actual=%0b required=0", busy); failures++; end checks++;
        for (int i = 0; i < 2; i++) begin
            #1;
            if (count !== 8'd0 || wrap !== 1'b0) begin $display("FAIL down_hold[%0d] actual=%0d/%0b required=0/0", i, count, wrap); failures++; end checks++;
            tick();
        end
        $display("txn test_down_oneshot count=%0d done=%0b", count, done);
    endtask

    // Continues from the DONE state left by test_down_oneshot.
    task automatic test_restart_from_done();
        en = 1;
        do_start(8'd2, 1'b0, 1'b1);
        if (count !== 8'd0 || busy !== 1'b1 || done !== 1'b0) begin
            $display("FAIL restart_state actual=%0d/%0b/%0b required=0/1/0", count, busy, done); failures++;
        end
        checks++;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (count !== 8'(i))   begin $display("FAIL restart_count[%0d] actual=%0d required=%0d", i, count, i); failures++; end checks++;
            if (wrap !== (i == 2)) begin $display("FAIL restart_wrap[%0d] actual=%0b required=%0b", i, wrap, i == 2); failures++; end checks++;
            tick();
        end
        if (done !== 1'b1 || count !== 8'd2) begin $display("FAIL restart_end actual=%0b/%0d required=1/2", done, count); failures++; end checks++;
        en = 0;
        $display("txn test_restart_from_done count=%0d", count);
    endtask

    task automatic test_load_clamp();
        do_reset();
        do_start(8'd9, 1'b0, 1'b0);
        en = 1;
        repeat (5) tick();
        en = 0;
        if (count !== 8'd5) begin $display("FAIL load_pre actual=%0d required=5", count); failures++; end checks++;
        load = 1; load_val = 8'd20; en = 1;
        #1;
        if (wrap !== 1'b0) begin $display("FAIL load_wrap actual=%0b required=0", wrap); failures++; end checks++;
        tick();
        load = 0;
        if (count !== 8'd9 || tc !== 1'b1) begin $display("FAIL load_clamp actual=%0d/%0b required=9/1", count, tc); failures++; end checks++;
        #1;
        if (wrap !== 1'b1) begin $display("FAIL load_next_wrap actual=%0b required=1", wrap); failures++; end checks++;
        tick();
        en = 0;
        if (count !== 8'd0) begin $display("FAIL load_after_wrap actual=%0d required=0", count); failures++; end checks++;
        $display("txn test_load_clamp count=%0d", count);
    endtask

    task automatic test_priority();
        do_reset();
        do_start(8'd6, 1'b1, 1'b0);
        en = 1;
        repeat (2) tick();
        clr = 1; load = 1; load_val = 8'd1; start = 1; limit = 8'd3; dir = 0;
        #1;
        if (wrap !== 1'b0) begin $display("FAIL prio_wrap actual=%0b required=0", wrap); failures++; end checks++;
        tick();
        clr = 0; load = 0; start = 0; en = 0;
        if (count !== 8'd6 || busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL prio_state actual=%0d/%0b/%0b required=6/0/0", count, busy, done); failures++;
        end
        checks++;
        do_start(8'd2, 1'b0, 1'b0);
        en = 1;
        repeat (2) tick();
        rst = 1;
        #1;
        if (wrap !== 1'b0) begin $display("FAIL rst_wrap actual=%0b required=0", wrap); failures++; end checks++;
        tick();
        rst = 0; en = 0;
        if (count !== 8'd0 || mirror !== 8'd255 || tc !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL rst_midrun actual=%0d/%0d/%0b/%0b/%0b required=0/255/0/0/0", count, mirror, tc, busy, done); failures++;
        end
        checks++;
        $display("txn test_priority count=%0d", count);
    endtask

    task automatic test_limit_zero();
        logic [2:0] pattern;
        pattern = 3'b101;
        do_reset();
        do_start(8'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            en = pattern[2 - i];
            #1;
            if (count !== 8'd0 || tc !== 1'b1) begin $display("FAIL lim0_count[%0d] actual=%0d/%0b required=0/1", i, count, tc); failures++; end checks++;
            if (wrap !== pattern[2 - i]) begin $display("FAIL lim0_wrap[%0d] actual=%0b required=%0b", i, wrap, pattern[2 - i]); failures++; end checks++;
            tick();
        end
        en = 0;
        $display("txn test_limit_zero count=%0d", count);
    endtask

    // Reference model: the rules applied in their stated priority on plain ints.
    // m_state: 0 idle, 1 run, 2 done.
    task automatic test_random();
        int m_state, m_cnt, m_lim, m_dir, m_os, term, sv, exp_wrap, nwraps;
        do_reset();
        m_state = 0; m_cnt = 0; m_lim = 255; m_dir = 0; m_os = 0; nwraps = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            rst      = ($urandom_range(0, 99) == 0);
            clr      = ($urandom_range(0, 29) == 0);
            load     = ($urandom_range(0, 19) == 0);
            start    = ($urandom_range(0, 7) == 0);
            en       = ($urandom_range(0, 3) != 0);
            load_val = 8'($urandom_range(0, 255));
            limit    = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 6)) : 8'($urandom_range(0, 255));
            dir      = 1'($urandom_range(0, 1));
            oneshot  = 1'($urandom_range(0, 1));
            #1;
            term = m_dir ? 0 : m_lim;
            sv   = m_dir ? m_lim : 0;
            exp_wrap = (m_state == 1 && en && !clr && !load && !rst && m_cnt == term) ? 1 : 0;
            nwraps += exp_wrap;
            if (count !== 8'(m_cnt))           begin $display("FAIL rnd_count[%0d] actual=%0d required=%0d", cyc, count, m_cnt); failures++; end checks++;
            if (mirror !== 8'(m_lim - m_cnt))  begin $display("FAIL rnd_mirror[%0d] actual=%0d required=%0d", cyc, mirror, m_lim - m_cnt); failures++; end checks++;
            if (tc !== (m_cnt == term))        begin $display("FAIL rnd_tc[%0d] actual=%0b required=%0b", cyc, tc, m_cnt == term); failures++; end checks++;
            if (wrap !== 1'(exp_wrap))         begin $display("FAIL rnd_wrap[%0d] actual=%0b required=%0d", cyc, wrap, exp_wrap); failures++; end checks++;
            if (busy !== (m_state == 1) || done !== (m_state == 2)) begin
                $display("FAIL rnd_state[%0d] actual=%0b/%0b required=%0b/%0b", cyc, busy, done, m_state == 1, m_state == 2); failures++;
            end
            checks++;
            if (rst) begin
                m_state = 0; m_cnt = 0; m_lim = 255; m_dir = 0; m_os = 0;
            end else if (clr) begin
                m_cnt = sv; m_state = 0;
            end else if (load) begin
                m_cnt = (int'(load_val) < m_lim) ? int'(load_val) : m_lim;
            end else if (start && m_state != 1) begin
                m_lim = limit; m_dir = dir; m_os = oneshot;
                m_cnt = dir ? int'(limit) : 0;
                m_state = 1;
            end else if (m_state == 1 && en) begin
                if (m_cnt == term) begin
                    if (m_os) m_state = 2;
                    else      m_cnt = sv;
                end else begin
                    m_cnt = m_dir ? m_cnt - 1 : m_cnt + 1;
                end
            end
            tick();
        end
        quiet_inputs();
        $display("txn test_random cycles=2000 wraps=%0d", nwraps);
    endtask

    initial begin
        quiet_inputs();
        test_reset();
        test_up_wrap();
        test_down_oneshot();
        test_restart_from_done();
        test_load_clamp();
        test_priority();
        test_limit_zero();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
